// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/nbit_subtractor.sv
// N-bit subtractor: o_d = i_a - i_b, o_borrow set when i_a < i_b (unsigned).
module nbit_subtractor #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    output logic [N-1:0] o_d,
    output logic         o_borrow
);

    logic carry;

    // Two's-complement subtraction; carry-out high means no borrow.
    assign {carry, o_d} = {1'b0, i_a} + {1'b0, ~i_b} + (N + 1)'(1);
    assign o_borrow     = ~carry;

endmodule

// File: rtl/seq_restoring_divider.sv
// Multi-cycle restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// One quotient bit per cycle behind a valid/ready handshake on both sides.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEFAULT
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_signed,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_quotient,
    output logic [XLEN-1:0] o_remainder,
    output logic            o_div_by_zero
);

    localparam int unsigned CntW = $clog2(XLEN);

    state_e            state_q;
    logic              first_q;
    logic              signed_q;
    logic              q_neg_q;
    logic              r_neg_q;
    logic [XLEN-1:0]   dvd_q;
    logic [XLEN-1:0]   dvs_q;
    logic [XLEN-1:0]   rem_q;
    logic [CntW-1:0]   cnt_q;
    logic [XLEN-1:0]   quotient_q;
    logic [XLEN-1:0]   remainder_q;
    logic              dbz_q;

    logic [XLEN:0]     shifted;
    logic [XLEN:0]     trial;
    logic              borrow;
    logic              restore;
    logic [XLEN-1:0]   rem_d;
    logic [XLEN-1:0]   quo_d;
    logic              dvd_neg;
    logic              dvs_neg;

    assign shifted = {rem_q, dvd_q[XLEN-1]};

    nbit_subtractor #(
        .N(XLEN + 1)
    ) u_trial_sub (
        .i_a      (shifted),
        .i_b      ({1'b0, dvs_q}),
        .o_d      (trial),
        .o_borrow (borrow)
    );

    // trial[XLEN] is zero whenever there is no borrow; folding it in is harmless.
    assign restore = borrow | trial[XLEN];
    assign rem_d   = restore ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    assign quo_d   = {dvd_q[XLEN-2:0], ~restore};
    assign dvd_neg = signed_q & dvd_q[XLEN-1];
    assign dvs_neg = signed_q & dvs_q[XLEN-1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            first_q     <= 1'b0;
            signed_q    <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        dvd_q    <= i_dividend;
                        dvs_q    <= i_divisor;
                        signed_q <= i_signed;
                        first_q  <= 1'b1;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    if (first_q) begin
                        // Raw operands were registered on acceptance; convert here.
                        first_q <= 1'b0;
                        if (dvs_q == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= dvd_q;
                            dbz_q       <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            dvd_q   <= dvd_neg ? -dvd_q : dvd_q;
                            dvs_q   <= dvs_neg ? -dvs_q : dvs_q;
                            q_neg_q <= dvd_neg ^ dvs_neg;
                            r_neg_q <= dvd_neg;
                            rem_q   <= '0;
                            cnt_q   <= CntW'(XLEN - 1);
                        end
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= quo_d;
                        cnt_q <= cnt_q - CntW'(1);
                        if (cnt_q == '0) begin
                            quotient_q  <= q_neg_q ? -quo_d : quo_d;
                            remainder_q <= r_neg_q ? -rem_d : rem_d;
                            dbz_q       <= 1'b0;
                            state_q     <= StDone;
                        end
                    end
                end
                StDone: begin
                    if (i_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_ready       = (state_q == StIdle);
    assign o_valid       = (state_q == StDone);
    assign o_quotient    = quotient_q;
    assign o_remainder   = remainder_q;
    assign o_div_by_zero = dbz_q;

endmodule
